// File: rtl/ascon_tag_verify.sv
// ascon_tag_verify
//   Decryption-side tag check. Collects the received 128-bit tag as N_WORDS
//   words of WORD_W bits, latches the tag computed by finalization, compares
//   the two in exactly N_WORDS cycles regardless of their contents, then
//   reports the verdict. Plaintext release downstream is gated on auth_ok.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begins a verification (only honoured in IDLE)
//   abort           cancels any operation, highest priority
//   rx_tag_data     received tag word; word 0 is tag[127:128-WORD_W]
//   rx_tag_valid    rx_tag_data valid
//   rx_tag_ready    a word is accepted this cycle (combinational)
//   calc_tag        tag computed by finalization
//   calc_tag_valid  calc_tag valid this cycle (first one per run is kept)
//   busy            high in LOAD, CMP and DONE
//   result_valid    one-cycle verdict strobe
//   auth_ok         tags matched, held until next start/abort/reset
//   auth_fail       tags differ, held until next start/abort/reset
module ascon_tag_verify #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] rx_tag_data,
   input  logic              rx_tag_valid,
   output logic              rx_tag_ready,
   input  logic [127:0]      calc_tag,
   input  logic              calc_tag_valid,
   output logic              busy,
   output logic              result_valid,
   output logic              auth_ok,
   output logic              auth_fail
);

   localparam int N_WORDS = 128 / WORD_W;
   localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int CNT_W   = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, LOAD, CMP, DONE} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic              have_rx, have_calc;
   logic [WORD_W-1:0] rx_words   [N_WORDS];
   logic [WORD_W-1:0] calc_words [N_WORDS];
   logic [127:0]      calc_tag_r;
   logic [WORD_W-1:0] diff_acc;

   logic              hs, last_hs, rx_complete, calc_complete, cmp_last;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] cur_diff;

   // Slice k of the latched computed tag, MSB-first like the rx stream.
   for (genvar k = 0; k < N_WORDS; k++) begin : g_calc
      assign calc_words[k] = calc_tag_r[128-(k+1)*WORD_W +: WORD_W];
   end

   assign idx      = cnt[IDX_W-1:0];
   assign hs       = rx_tag_valid & rx_tag_ready;
   assign last_hs  = hs && (cnt == CNT_W'(N_WORDS - 1));
   assign cmp_last = (cnt == CNT_W'(N_WORDS - 1));
   assign cur_diff = rx_words[idx] ^ calc_words[idx];

   // Completion looks through this cycle's handshake and calc strobe so that
   // CMP starts on the very edge that stores the last missing piece.
   assign rx_complete   = have_rx | last_hs;
   assign calc_complete = have_calc | calc_tag_valid;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (rx_complete && calc_complete) state_next = CMP;
            CMP:     if (cmp_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Combinational output
   always_comb begin
      rx_tag_ready = (state == LOAD) && (cnt < CNT_W'(N_WORDS));
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy         <= 1'b0;
         result_valid <= 1'b0;
         auth_ok      <= 1'b0;
         auth_fail    <= 1'b0;
         cnt          <= '0;
         have_rx      <= 1'b0;
         have_calc    <= 1'b0;
         calc_tag_r   <= '0;
         diff_acc     <= '0;
         for (int i = 0; i < N_WORDS; i++) rx_words[i] <= '0;
      end else begin
         busy         <= (state_next != IDLE);
         result_valid <= (state == CMP) && (state_next == DONE);

         if (abort || state == DONE) begin
            // Wipe tag material after every run and on cancel.
            cnt        <= '0;
            have_rx    <= 1'b0;
            have_calc  <= 1'b0;
            calc_tag_r <= '0;
            diff_acc   <= '0;
            for (int i = 0; i < N_WORDS; i++) rx_words[i] <= '0;
            if (abort) begin
               auth_ok   <= 1'b0;
               auth_fail <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     cnt       <= '0;
                     have_rx   <= 1'b0;
                     have_calc <= 1'b0;
                     diff_acc  <= '0;
                     auth_ok   <= 1'b0;
                     auth_fail <= 1'b0;
                  end
               end
               LOAD: begin
                  if (hs) begin
                     rx_words[idx] <= rx_tag_data;
                     cnt           <= cnt + CNT_W'(1);
                     if (last_hs) have_rx <= 1'b1;
                  end
                  if (calc_tag_valid && !have_calc) begin
                     calc_tag_r <= calc_tag;
                     have_calc  <= 1'b1;
                  end
                  // Counter is reused as the CMP slice index.
                  if (state_next == CMP) cnt <= '0;
               end
               CMP: begin
                  // No early exit: every slice is visited on every run.
                  diff_acc <= diff_acc | cur_diff;
                  cnt      <= cnt + CNT_W'(1);
                  if (cmp_last) begin
                     auth_ok   <= ((diff_acc | cur_diff) == '0);
                     auth_fail <= ((diff_acc | cur_diff) != '0);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascon_tag_verify.sv
module tb_ascon_tag_verify;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, abort;
   // 32-bit instance
   logic         start;
   logic [31:0]  rx_data;
   logic         rx_valid, calc_valid;
   logic [127:0] calc;
   logic         rx_ready, busy, rv, ok, fl;
   // 64-bit instance
   logic         start64;
   logic [63:0]  rx_data64;
   logic         rx_valid64, calc_valid64;
   logic [127:0] calc64;
   logic         rx_ready64, busy64, rv64, ok64, fl64;

   int n_cmp = 0;
   int n_bad = 0;

   logic [127:0] tag_good;
   logic [127:0] tag_bit0;
   logic [127:0] tag_bit127;
   logic [31:0]  w32 [4];
   logic [63:0]  w64 [2];

   ascon_tag_verify #(.WORD_W(32)) dut32 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rx_tag_data(rx_data), .rx_tag_valid(rx_valid), .rx_tag_ready(rx_ready),
      .calc_tag(calc), .calc_tag_valid(calc_valid),
      .busy(busy), .result_valid(rv), .auth_ok(ok), .auth_fail(fl)
   );

   ascon_tag_verify #(.WORD_W(64)) dut64 (
      .clk(clk), .rst(rst), .start(start64), .abort(abort),
      .rx_tag_data(rx_data64), .rx_tag_valid(rx_valid64), .rx_tag_ready(rx_ready64),
      .calc_tag(calc64), .calc_tag_valid(calc_valid64),
      .busy(busy64), .result_valid(rv64), .auth_ok(ok64), .auth_fail(fl64)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Four back-to-back words of the good tag, calc presented with word 0.
   task automatic send4(input logic [127:0] ctag);
      for (int i = 0; i < 4; i++) begin
         rx_valid   = 1'b1;
         rx_data    = w32[i];
         calc_valid = (i == 0);
         calc       = ctag;
         tick();
      end
      rx_valid   = 1'b0;
      calc_valid = 1'b0;
   endtask

   task automatic wait32(output int n);
      n = 0;
      while (!rv && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic wait64(output int n);
      n = 0;
      while (!rv64 && n < 20) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      int k;
      logic [6:0] pat;

      tag_good   = 128'h0123456789ABCDEF_FEDCBA9876543210;
      tag_bit0   = 128'h0123456789ABCDEF_FEDCBA9876543211;
      tag_bit127 = 128'h8123456789ABCDEF_FEDCBA9876543210;
      w32[0] = 32'h01234567; w32[1] = 32'h89ABCDEF;
      w32[2] = 32'hFEDCBA98; w32[3] = 32'h76543210;
      w64[0] = 64'h0123456789ABCDEF; w64[1] = 64'hFEDCBA9876543210;

      rst = 1'b1; abort = 1'b0;
      start = 1'b0; rx_data = '0; rx_valid = 1'b0; calc = '0; calc_valid = 1'b0;
      start64 = 1'b0; rx_data64 = '0; rx_valid64 = 1'b0; calc64 = '0; calc_valid64 = 1'b0;
      tick(); tick();
      check_val("rst_busy", busy, 0);
      check_val("rst_rv", rv, 0);
      check_val("rst_ok", ok, 0);
      check_val("rst_fail", fl, 0);
      check_val("rst_ready", rx_ready, 0);
      rst = 1'b0;
      tick();
      check_val("idle_ready", rx_ready, 0);

      // 1: match
      do_start();
      check_val("t1_busy", busy, 1);
      check_val("t1_ready", rx_ready, 1);
      send4(tag_good);
      check_val("t1_cmp_ok", ok, 0);
      wait32(n);
      check_val("t1_latency", n, 4);
      check_val("t1_ok", ok, 1);
      check_val("t1_fail", fl, 0);
      tick();
      check_val("t1_rv_pulse", rv, 0);
      check_val("t1_ok_held", ok, 1);
      check_val("t1_busy_idle", busy, 0);

      // 2: single-bit mismatch, same timing
      do_start();
      check_val("t2_ok_cleared", ok, 0);
      send4(tag_bit0);
      wait32(n);
      check_val("t2_latency", n, 4);
      check_val("t2_ok", ok, 0);
      check_val("t2_fail", fl, 1);
      tick();

      // 3: calc first, stalled stream
      do_start();
      pat = 7'b1101001;  // bit i = rx_valid in LOAD cycle i: 1,0,0,1,0,1,1
      k = 0;
      for (int i = 0; i < 7; i++) begin
         calc_valid = (i == 0);
         calc       = tag_good;
         rx_valid   = pat[i];
         rx_data    = w32[k % 4];
         check_val("t3_ready", rx_ready, 1);
         tick();
         if (pat[i]) k++;
      end
      rx_valid = 1'b0; calc_valid = 1'b0;
      check_val("t3_ready_off", rx_ready, 0);
      wait32(n);
      check_val("t3_latency", n, 4);
      check_val("t3_ok", ok, 1);
      tick();

      // 4: abort after two words, abort beats a handshake in the same cycle
      do_start();
      calc_valid = 1'b1; calc = tag_good;
      for (int i = 0; i < 2; i++) begin
         rx_valid = 1'b1; rx_data = w32[i];
         tick();
         calc_valid = 1'b0;
      end
      rx_valid = 1'b1; rx_data = w32[2]; abort = 1'b1;
      tick();
      abort = 1'b0; rx_valid = 1'b0;
      check_val("t4_busy", busy, 0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rv) seen++;
         tick();
      end
      check_val("t4_no_rv", seen, 0);
      do_start();
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1; rx_data = w32[i];
         tick();
      end
      rx_valid = 1'b0;
      calc_valid = 1'b1; calc = tag_good;
      tick();
      calc_valid = 1'b0;
      wait32(n);
      check_val("t4_latency", n, 4);
      check_val("t4_ok", ok, 1);
      tick();

      // 5a: reset in the second CMP cycle
      do_start();
      send4(tag_good);
      tick();
      rst = 1'b1;
      #1;
      check_val("t5a_busy", busy, 0);
      check_val("t5a_rv", rv, 0);
      check_val("t5a_ok", ok, 0);
      check_val("t5a_fail", fl, 0);
      #2;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rv) seen++;
      end
      check_val("t5a_no_rv", seen, 0);

      // 5b: start during CMP is ignored
      do_start();
      send4(tag_bit0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait32(n);
      check_val("t5b_latency", n, 3);
      check_val("t5b_fail", fl, 1);
      check_val("t5b_ok", ok, 0);
      tick();
      check_val("t5b_idle", busy, 0);

      // 6: 64-bit words
      start64 = 1'b1; tick(); start64 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rx_valid64 = 1'b1; rx_data64 = w64[i];
         calc_valid64 = (i == 0); calc64 = tag_good;
         check_val("t6_ready", rx_ready64, 1);
         tick();
      end
      rx_valid64 = 1'b0; calc_valid64 = 1'b0;
      wait64(n);
      check_val("t6_latency", n, 2);
      check_val("t6_ok", ok64, 1);
      check_val("t6_fail", fl64, 0);
      tick();
      start64 = 1'b1; tick(); start64 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rx_valid64 = 1'b1; rx_data64 = w64[i];
         calc_valid64 = (i == 0); calc64 = tag_bit127;
         tick();
      end
      rx_valid64 = 1'b0; calc_valid64 = 1'b0;
      wait64(n);
      check_val("t6_mis_latency", n, 2);
      check_val("t6_mis_fail", fl64, 1);
      check_val("t6_mis_ok", ok64, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ascon_tag_verify.md
Name: ascon_tag_verify

Overview:
Decryption-side tag check for the Ascon core, the receive counterpart of tag generation.
- Collects the received 128-bit tag as a stream of WORD_W-bit words.
- Latches the tag computed by finalization.
- Compares the two in a fixed number of cycles, independent of the data, then reports pass or fail.
- Sits between the ciphertext input stream and the decryption plaintext-release logic; plaintext is released only on auth_ok.

Parameters:
- WORD_W, 32, width of a received tag word. Legal values are 32 or 64. N_WORDS = 128/WORD_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a verification. Acted on only in IDLE.
- abort  input  1  cancels any operation in progress.
- rx_tag_data  input  WORD_W  received tag word. Word 0 maps to tag[127:128-WORD_W].
- rx_tag_valid  input  1  rx_tag_data is valid.
- rx_tag_ready  output  1  block accepts a word this cycle.
- calc_tag  input  128  computed tag from finalization.
- calc_tag_valid  input  1  calc_tag is valid this cycle.
- busy  output  1  high in LOAD, CMP and DONE.
- result_valid  output  1  one-cycle pulse when the verdict is available.
- auth_ok  output  1  tags matched. Held until next start, abort or reset.
- auth_fail  output  1  tags differ. Held until next start, abort or reset.

Behaviour:
- Reset (async, rst=1): every output is 0; state is IDLE; all internal tag registers, the word counter and the diff accumulator are 0.
- All outputs are registered, except rx_tag_ready, which is decoded from state and the word counter.
- IDLE:
  - rx_tag_ready=0.
  - start=1 -> LOAD. This clears the word counter, have_rx, have_calc, the diff accumulator, auth_ok and auth_fail.
- LOAD:
  - rx_tag_ready=1 while the word counter is below N_WORDS.
  - On a handshake (rx_tag_valid & rx_tag_ready), the word is stored at slice index = counter and the counter increments. have_rx is set when the last word is stored.
  - calc_tag_valid=1 with have_calc=0 latches calc_tag and sets have_calc. Later calc_tag_valid pulses are ignored.
  - calc may arrive before, during or after the rx words, including in the same cycle as the last rx handshake.
  - When have_rx and have_calc are both set -> CMP on the next edge.
- CMP:
  - Lasts exactly N_WORDS cycles, with slice index k = 0..N_WORDS-1.
  - Each cycle: diff_acc <= diff_acc | (rx_slice[k] ^ calc_slice[k]), where diff_acc is WORD_W bits wide.
  - There is no early exit on a mismatch. The cycle count is data-independent.
  - Then -> DONE.
- DONE:
  - For one cycle: result_valid=1, auth_ok=(diff_acc==0), auth_fail=~auth_ok.
  - Then -> IDLE.
  - On leaving DONE, the received-tag, calc-tag and diff registers are zeroed.
- Latency: let T be the cycle in which the LOAD completion condition becomes true. The CMP cycles are T+1..T+N_WORDS, and result_valid is high in cycle T+N_WORDS+1.
- abort=1 in any state:
  - Next state is IDLE; result_valid is not asserted.
  - auth_ok, auth_fail and all internal registers are cleared.
  - abort has priority over start, handshakes and calc_tag_valid in the same cycle.
- Ignored inputs:
  - start outside IDLE (no restart, no effect).
  - calc_tag_valid outside LOAD.
  - rx_tag_valid while rx_tag_ready=0; the word is not consumed.
- auth_ok and auth_fail are never both 1. Both are 0 from start until result_valid.
- Reset asserted mid-operation aborts immediately (async). No result is produced, and the block resumes in IDLE after rst falls.

Test Plan:
1. Match, WORD_W=32:
   - Stimulus: start; words 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210 on back-to-back cycles; calc_tag=128'h0123456789ABCDEF_FEDCBA9876543210 with the first word.
   - Required response: result_valid exactly 5 cycles after the last handshake; auth_ok=1, auth_fail=0.
2. Single-bit mismatch:
   - Stimulus: same as 1, but calc_tag bit 0 flipped.
   - Required response: auth_fail=1, auth_ok=0; result_valid in the same cycle as in scenario 1 (constant time).
3. Calc first, stalled stream:
   - Stimulus: calc_tag_valid in the first LOAD cycle; rx_tag_valid toggling 1,0,0,1,0,1,1.
   - Required response: rx_tag_ready stays 1 until the 4th handshake; result_valid 5 cycles after the 4th handshake; auth_ok=1.
4. Abort mid-load:
   - Stimulus: abort after 2 words accepted; then a new start with a matching tag.
   - Required response: no result_valid for the aborted run; busy=0 the cycle after abort; second run gives auth_ok=1 with no stale words carried over.
5. Reset and start during CMP:
   - Stimulus (a): rst pulse in the 2nd CMP cycle. Required: all outputs 0 immediately, no result_valid.
   - Stimulus (b): start pulse during CMP. Required: ignored, with the verdict unchanged.
6. WORD_W=64:
   - Stimulus: words 64'h0123456789ABCDEF, 64'hFEDCBA9876543210.
   - Required response: 2 CMP cycles; auth_ok=1; result_valid 3 cycles after the last handshake.
